pixel_stream_rx: RTL

Receive-side counterpart of the LED-array pixel writer. Samples a two-wire serial pixel stream (data + shift clock, asynchronous to CLK), deserialises it into bytes and assembles fixed-length frames. A frame is delimited by bus idle. Completed frames are double-buffered and exposed through a registered read port. Used as an on-board loopback or bench monitor that checks what the array driver actually emitted.

---
 rtl/pixel_stream_rx_pkg.sv | 17 +
 rtl/pixel_rx_sync.sv | 38 +++
 rtl/pixel_stream_rx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pixel_stream_rx_pkg.sv
// pixel_stream_rx_pkg -- shared FSM encoding and frame defaults for the pixel link (rev 1.0)
`default_nettype none

package pixel_stream_rx_pkg;

  localparam int DEF_BYTES_PER_FRAME = 16;
  localparam int DEF_IDLE_TIMEOUT    = 250;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CLOSE = 2'd2
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/pixel_rx_sync.sv
// pixel_rx_sync -- synchronises SCLK/SDATA into the CLK domain and flags SCLK rising edges (rev 1.0)
`default_nettype none

module pixel_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_in,
  input  logic sdata_in,
  output logic sclk_rise,
  output logic sdata_s
);

  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] sdata_sr;
  logic                   sclk_prev;

  // sdata_s is registered alongside sclk_rise so the bit lines up with its edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sr   <= '0;
      sdata_sr  <= '0;
      sclk_prev <= 1'b0;
      sclk_rise <= 1'b0;
      sdata_s   <= 1'b0;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk_in};
      sdata_sr  <= {sdata_sr[SYNC_STAGES-2:0], sdata_in};
      sclk_prev <= sclk_sr[SYNC_STAGES-1];
      sclk_rise <= sclk_sr[SYNC_STAGES-1] & ~sclk_prev;
      sdata_s   <= sdata_sr[SYNC_STAGES-1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/pixel_stream_rx.sv
// pixel_stream_rx -- serial pixel stream receiver with double-buffered frame store (rev 1.0)
`default_nettype none

module pixel_stream_rx
  import pixel_stream_rx_pkg::*;
#(
  parameter int BYTES_PER_FRAME = DEF_BYTES_PER_FRAME,
  parameter int IDLE_TIMEOUT    = DEF_IDLE_TIMEOUT,
  parameter int MSB_FIRST       = 1,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               i_SDATA,
  input  logic                               i_SCLK,
  input  logic [$clog2(BYTES_PER_FRAME)-1:0] i_rd_addr,
  output logic [7:0]                         o_rd_data,
  output logic                               o_frame_done,
  output logic [15:0]                        o_frame_count,
  output logic                               o_err_short,
  output logic                               o_err_partial,
  output logic                               o_err_overrun,
  output logic                               o_busy
);

  localparam int             AW      = $clog2(BYTES_PER_FRAME);
  localparam int             TW      = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [AW:0]    FULL    = (AW+1)'(BYTES_PER_FRAME);

  logic          sclk_rise;
  logic          sdata_s;
  rx_state_t     state;
  rx_state_t     state_nx;
  logic [7:0]    shreg;
  logic [7:0]    shift_val;
  logic [2:0]    bit_cnt;
  logic [AW:0]   byte_cnt;
  logic [TW-1:0] timeout;
  logic          front_sel;
  logic [7:0]    mem [2][BYTES_PER_FRAME];

  pixel_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (CLK),
    .rst_n    (RST_N),
    .sclk_in  (i_SCLK),
    .sdata_in (i_SDATA),
    .sclk_rise(sclk_rise),
    .sdata_s  (sdata_s)
  );

  assign shift_val = (MSB_FIRST != 0) ? {shreg[6:0], sdata_s} : {sdata_s, shreg[7:1]};
  assign o_busy    = (state != ST_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // An edge arriving on the expiry cycle wins over the timeout
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (sclk_rise) state_nx = ST_RECV;
      ST_RECV:  if (!sclk_rise && timeout == TO_LAST) state_nx = ST_CLOSE;
      ST_CLOSE: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg         <= '0;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      timeout       <= '0;
      front_sel     <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_count <= '0;
      o_err_short   <= 1'b0;
      o_err_partial <= 1'b0;
      o_err_overrun <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < BYTES_PER_FRAME; i++)
          mem[b][i] <= '0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sclk_rise) begin
            shreg    <= shift_val;
            bit_cnt  <= 3'd1;
            byte_cnt <= '0;
            timeout  <= '0;
          end
        end
        ST_RECV: begin
          if (sclk_rise) begin
            shreg   <= shift_val;
            bit_cnt <= bit_cnt + 3'd1;
            timeout <= '0;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt == FULL) begin
                o_err_overrun <= 1'b1;
              end else begin
                mem[~front_sel][byte_cnt[AW-1:0]] <= shift_val;
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end else begin
            timeout <= timeout + 1'b1;
          end
        end
        ST_CLOSE: begin
          if (bit_cnt != 3'd0) begin
            o_err_partial <= 1'b1;
          end else if (byte_cnt != FULL) begin
            o_err_short <= 1'b1;
          end else begin
            front_sel     <= ~front_sel;
            o_frame_done  <= 1'b1;
            o_frame_count <= o_frame_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Reads use the pre-swap front_sel, so a swap becomes visible one cycle later
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) o_rd_data <= '0;
    else        o_rd_data <= mem[front_sel][i_rd_addr];
  end

endmodule

`default_nettype wire
